// File: rtl/hazard_unit_p.sv
// Hazard detection for an in-order pipeline: per-operand forwarding select,
// load-use stall/bubble sequencing and a saturating stall-cycle counter.
module hazard_unit_p #(
    parameter  int REG_AW = 3,
    parameter  int NSRC   = 2,
    parameter  int NSTAGE = 2,
    parameter  int CNT_W  = 16,
    localparam int FSEL_W = $clog2(NSTAGE + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NSRC*REG_AW-1:0]   src_addr,
    input  logic [NSRC-1:0]          src_used,
    input  logic [NSTAGE*REG_AW-1:0] stg_dest,
    input  logic [NSTAGE-1:0]        stg_load_reg,
    input  logic [NSTAGE-1:0]        stg_is_load,
    input  logic                     mem_resp,
    input  logic                     icache_stall,
    input  logic                     perf_clr,
    output logic [NSRC*FSEL_W-1:0]   fwd_sel,
    output logic                     stall,
    output logic                     bubble,
    output logic [CNT_W-1:0]         stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_BUBBLE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NSRC-1:0]  haz_vec;
    logic             ld_haz;
    logic             stall_raw, bubble_raw;

    genvar gi, gk;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic [NSTAGE-1:0] match;
            logic [NSTAGE-1:0] elig;
            logic [FSEL_W-1:0] sel;

            for (gk = 0; gk < NSTAGE; gk++) begin : g_stg
                assign match[gk] = src_used[gi] & stg_load_reg[gk] &
                    (src_addr[gi*REG_AW +: REG_AW] == stg_dest[gk*REG_AW +: REG_AW]);
            end

            // A load in stage 0 has no data yet, so it can never be a forwarding source.
            always_comb begin
                elig    = match;
                elig[0] = match[0] & ~stg_is_load[0];
                sel     = '0;
                for (int k = NSTAGE - 1; k >= 0; k--) begin
                    if (elig[k]) begin
                        sel = FSEL_W'(k + 1);
                    end
                end
            end

            assign haz_vec[gi] = match[0] & stg_is_load[0];
            assign fwd_sel[gi*FSEL_W +: FSEL_W] = rst_n ? sel : '0;
        end
    endgenerate

    assign ld_haz = |haz_vec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fetch stalls freeze the sequencer so a pending load-use is not lost.
    always_comb begin
        state_d = state_q;
        if (!icache_stall) begin
            case (state_q)
                ST_RUN: begin
                    if (ld_haz) begin
                        state_d = mem_resp ? ST_BUBBLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp) begin
                        state_d = ST_BUBBLE;
                    end
                end
                ST_BUBBLE: state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        stall_raw  = 1'b0;
        bubble_raw = 1'b0;
        case (state_q)
            ST_RUN:    stall_raw = ld_haz;
            ST_WAIT:   stall_raw = 1'b1;
            ST_BUBBLE: begin
                stall_raw  = 1'b1;
                bubble_raw = 1'b1;
            end
            default: begin
                stall_raw  = 1'b0;
                bubble_raw = 1'b0;
            end
        endcase
    end

    assign stall  = rst_n & stall_raw;
    assign bubble = rst_n & bubble_raw;

    always_comb begin
        cnt_d = cnt_q;
        if (perf_clr) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_unit_p.sv
// Directed-vector bench: a driver pushes per-cycle expectations, a negedge
// monitor pops and compares against a default and a 4-bit-counter instance.
module tb_hazard_unit_p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  src_addr;
    logic [1:0]  src_used;
    logic [5:0]  stg_dest;
    logic [1:0]  stg_load_reg;
    logic [1:0]  stg_is_load;
    logic        mem_resp;
    logic        icache_stall;
    logic        perf_clr;

    logic [3:0]  fsel_a, fsel_b;
    logic        stall_a, stall_b, bubble_a, bubble_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    hazard_unit_p u_dut16 (
        .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .src_used(src_used),
        .stg_dest(stg_dest), .stg_load_reg(stg_load_reg), .stg_is_load(stg_is_load),
        .mem_resp(mem_resp), .icache_stall(icache_stall), .perf_clr(perf_clr),
        .fwd_sel(fsel_a), .stall(stall_a), .bubble(bubble_a), .stall_cycles(cnt_a)
    );

    hazard_unit_p #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .src_used(src_used),
        .stg_dest(stg_dest), .stg_load_reg(stg_load_reg), .stg_is_load(stg_is_load),
        .mem_resp(mem_resp), .icache_stall(icache_stall), .perf_clr(perf_clr),
        .fwd_sel(fsel_b), .stall(stall_b), .bubble(bubble_b), .stall_cycles(cnt_b)
    );

    typedef struct packed {
        logic [15:0] id;
        logic        es;
        logic        eb;
        logic [3:0]  ef;
        logic [15:0] c16;
        logic [3:0]  c4;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] vid = 16'd0;
    logic [15:0] c16_m = 16'd0;
    logic [3:0]  c4_m = 4'd0;

    // Operand/stage pairs written in octal as {op1/stage1, op0/stage0}.
    localparam logic [5:0] H_ADDR = 6'o03;
    localparam logic [5:0] H_DEST = 6'o33;

    task automatic cyc(input logic [5:0] a, input logic [1:0] u, input logic [5:0] d,
                       input logic [1:0] lr, input logic [1:0] il, input logic mr,
                       input logic ic, input logic clr, input logic rn,
                       input logic es, input logic eb, input logic [3:0] ef);
        exp_t e;
        src_addr = a; src_used = u; stg_dest = d; stg_load_reg = lr;
        stg_is_load = il; mem_resp = mr; icache_stall = ic; perf_clr = clr; rst_n = rn;
        e = '{id: vid, es: es, eb: eb, ef: ef, c16: c16_m, c4: c4_m};
        sb.push_back(e);
        vid = vid + 16'd1;
        if (!rn || clr) begin
            c16_m = 16'd0;
            c4_m  = 4'd0;
        end else if (es) begin
            if (c16_m != 16'hFFFF) c16_m = c16_m + 16'd1;
            if (c4_m != 4'hF) c4_m = c4_m + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // Load-use hazard on operand 0: stage 0 excluded, so stage 1 forwards (sel 2).
    task automatic haz(input logic mr, input logic ic, input logic clr,
                       input logic es, input logic eb);
        cyc(H_ADDR, 2'b01, H_DEST, 2'b11, 2'b01, mr, ic, clr, 1'b1, es, eb, 4'h2);
    endtask

    // Same operands with the stage-0 instruction no longer a load.
    task automatic nohaz();
        cyc(H_ADDR, 2'b01, H_DEST, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (stall_a !== e.es || bubble_a !== e.eb || fsel_a !== e.ef || cnt_a !== e.c16 ||
                stall_b !== e.es || bubble_b !== e.eb || fsel_b !== e.ef || cnt_b !== e.c4) begin
                n_bad++;
                $display("FAIL vec%0d: got stall=%b/%b bubble=%b/%b fwd_sel=%h/%h cnt=%0d/%0d, required stall=%b bubble=%b fwd_sel=%h cnt=%0d/%0d",
                         e.id, stall_a, stall_b, bubble_a, bubble_b, fsel_a, fsel_b,
                         cnt_a, cnt_b, e.es, e.eb, e.ef, e.c16, e.c4);
            end else begin
                $display("vec%0d ok: stall=%b bubble=%b fwd_sel=%h cnt=%0d/%0d",
                         e.id, stall_a, bubble_a, fsel_a, cnt_a, cnt_b);
            end
        end
    end

    initial begin
        rst_n = 1'b0; src_addr = '0; src_used = '0; stg_dest = '0; stg_load_reg = '0;
        stg_is_load = '0; mem_resp = 1'b0; icache_stall = 1'b0; perf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset forces outputs low even with a live load-use match.
        cyc(6'o25, 2'b11, 6'o55, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        // Forwarding patterns.
        cyc(6'o25, 2'b11, 6'o55, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1);
        cyc(6'o25, 2'b11, 6'o55, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2);
        cyc(6'o61, 2'b11, 6'o60, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h8);
        cyc(6'o03, 2'b10, 6'o73, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        cyc(6'o03, 2'b11, 6'o33, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        // Load-use with three cycles of memory latency: RUN, WAIT x3, BUBBLE.
        haz(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        haz(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        haz(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        haz(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        haz(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        nohaz();
        // Immediate memory response: still one bubble.
        haz(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        haz(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        nohaz();
        // Fetch stall holds WAIT despite mem_resp; counter cleared mid-way.
        haz(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        haz(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        haz(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        haz(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        haz(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        nohaz();
        // Fetch stall in RUN keeps RUN, so no bubble follows.
        haz(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        nohaz();
        // Long WAIT saturates the 4-bit counter.
        for (int i = 0; i < 21; i++) haz(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        haz(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        haz(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Reset while in WAIT returns to RUN.
        cyc(H_ADDR, 2'b01, H_DEST, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        nohaz();
        nohaz();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
